// File: rtl/uart_tx_packet_arbiter_if.sv
// Requester and packet-FIFO handshake bundle for uart_tx_packet_arbiter.
// The slave modport is the arbiter's view; master is the requester/FIFO side.
interface uart_tx_packet_arbiter_if #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned DATA_WIDTH   = 192,
   parameter int unsigned AMOUNT_WIDTH = $clog2(DATA_WIDTH / 8),
   parameter int unsigned ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
   logic [NUM_REQ-1:0]              req_valid;
   logic [NUM_REQ*DATA_WIDTH-1:0]   req_data;
   logic [NUM_REQ*AMOUNT_WIDTH-1:0] req_amount;
   logic [NUM_REQ-1:0]              req_ready;
   logic [NUM_REQ-1:0]              req_drop;
   logic                            available_snd;
   logic                            snd_big_clk;
   logic [DATA_WIDTH-1:0]           data_snd_big;
   logic [AMOUNT_WIDTH-1:0]         amount_byte_snd_big;
   logic [ID_WIDTH-1:0]             grant_id;
   logic                            busy;

   modport slave (
      input  req_valid, req_data, req_amount, available_snd,
      output req_ready, req_drop, snd_big_clk, data_snd_big, amount_byte_snd_big, grant_id, busy
   );

   modport master (
      output req_valid, req_data, req_amount, available_snd,
      input  req_ready, req_drop, snd_big_clk, data_snd_big, amount_byte_snd_big, grant_id, busy
   );
endinterface

// File: rtl/uart_tx_packet_arbiter.sv
// Arbitrates NUM_REQ packet requesters onto the UART send FIFO, one packet per two cycles.
// Define PKT_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_packet_arbiter #(
   parameter int unsigned NUM_REQ      = 2,
   parameter int unsigned DATA_WIDTH   = 192,
   parameter int unsigned AMOUNT_WIDTH = $clog2(DATA_WIDTH / 8),
   parameter int unsigned ID_WIDTH     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input logic                      clk,
   input logic                      rst,
   uart_tx_packet_arbiter_if.slave  bus_io
);

   localparam logic [AMOUNT_WIDTH:0]   MaxBytesExt = (AMOUNT_WIDTH + 1)'(DATA_WIDTH / 8);
   localparam logic [AMOUNT_WIDTH-1:0] MaxBytes    = AMOUNT_WIDTH'(DATA_WIDTH / 8);

   typedef enum logic [0:0] {StIdle, StIssue} state_e;

   state_e                  state_q;
   logic [ID_WIDTH-1:0]     last_grant_q;
   logic [ID_WIDTH-1:0]     grant_id_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [AMOUNT_WIDTH-1:0] amount_q;
   logic [NUM_REQ-1:0]      ready_q;
   logic [NUM_REQ-1:0]      drop_q;
   logic                    strobe_q;
   logic                    busy_q;

   logic                    win_found;
   logic [ID_WIDTH-1:0]     win_idx;
   logic [ID_WIDTH-1:0]     scan_idx;
   int unsigned             scan_pos;
   logic [DATA_WIDTH-1:0]   win_data;
   logic [AMOUNT_WIDTH:0]   raw_amount_ext;
   logic [AMOUNT_WIDTH-1:0] win_amount;
   logic [NUM_REQ-1:0]      win_onehot;

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      scan_pos  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
`ifdef PKT_ARB_FIXED_PRIO_EN
         scan_pos = k;
`else
         scan_pos = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
`endif
         scan_idx = ID_WIDTH'(scan_pos);
         if (!win_found && bus_io.req_valid[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // Clamp is evaluated one bit wider so counts above the payload size are caught.
   always_comb begin
      win_data       = bus_io.req_data[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
      raw_amount_ext = {1'b0, bus_io.req_amount[32'(win_idx) * AMOUNT_WIDTH +: AMOUNT_WIDTH]};
      win_amount     = (raw_amount_ext > MaxBytesExt) ? MaxBytes
                                                      : raw_amount_ext[AMOUNT_WIDTH-1:0];
      win_onehot     = NUM_REQ'(1) << win_idx;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
         grant_id_q   <= '0;
         data_q       <= '0;
         amount_q     <= '0;
         ready_q      <= '0;
         drop_q       <= '0;
         strobe_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (win_found && bus_io.available_snd) begin
                  state_q    <= StIssue;
                  data_q     <= win_data;
                  amount_q   <= win_amount;
                  grant_id_q <= win_idx;
                  busy_q     <= 1'b1;
                  ready_q    <= win_onehot;
                  if (win_amount != '0) begin
                     strobe_q <= 1'b1;
                  end else begin
                     drop_q <= win_onehot;
                  end
               end
            end
            StIssue: begin
               state_q      <= StIdle;
               busy_q       <= 1'b0;
               ready_q      <= '0;
               drop_q       <= '0;
               strobe_q     <= 1'b0;
               last_grant_q <= grant_id_q;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus_io.req_ready           = ready_q;
   assign bus_io.req_drop            = drop_q;
   assign bus_io.snd_big_clk         = strobe_q;
   assign bus_io.data_snd_big        = data_q;
   assign bus_io.amount_byte_snd_big = amount_q;
   assign bus_io.grant_id            = grant_id_q;
   assign bus_io.busy                = busy_q;

endmodule

// File: tb/tb_uart_tx_packet_arbiter.sv
// Directed self-checking bench for uart_tx_packet_arbiter (NUM_REQ=2, DATA_WIDTH=192).
module tb_uart_tx_packet_arbiter;
   localparam int unsigned NR = 2;
   localparam int unsigned DW = 192;
   localparam int unsigned AW = 5;
   localparam int unsigned IW = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   last_model = 1;
   logic [DW-1:0] exp_data = '0;

   always #5 clk = ~clk;

   uart_tx_packet_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .AMOUNT_WIDTH(AW), .ID_WIDTH(IW)) bus ();

   uart_tx_packet_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .AMOUNT_WIDTH(AW), .ID_WIDTH(IW)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   // Flags bundle: {snd_big_clk, req_ready[1:0], req_drop[1:0], busy}
   function automatic logic [5:0] flags();
      return {bus.snd_big_clk, bus.req_ready, bus.req_drop, bus.busy};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
      bus.req_valid  = v;
      bus.req_amount = {a1, a0};
      bus.req_data   = {d1, d0};
   endtask

   task automatic test_reset();
      set_req(2'b00, '0, '0, '0, '0);
      bus.available_snd = 1'b1;
      rst = 1'b1;
      tick();
      checks++;
      if ({flags(), bus.grant_id} !== 7'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 0000000", {flags(), bus.grant_id});
      end
      checks++;
      if ({bus.data_snd_big, bus.amount_byte_snd_big} !== '0) begin
         errors++;
         $display("FAIL reset_payload got %h/%0d want 0/0", bus.data_snd_big, bus.amount_byte_snd_big);
      end
      rst = 1'b0;
      last_model = 1;
      tick();
   endtask

   task automatic test_single();
      set_req(2'b01, 5'd5, 5'd0, {24{8'hA5}}, '0);
      tick();
      checks++;
      if (flags() !== 6'b1_01_00_1) begin
         errors++;
         $display("FAIL single_flags got %b want 101001", flags());
      end
      checks++;
      if (bus.amount_byte_snd_big !== 5'd5 || bus.grant_id !== 1'b0) begin
         errors++;
         $display("FAIL single_amt_id got %0d/%0d want 5/0", bus.amount_byte_snd_big, bus.grant_id);
      end
      checks++;
      if (bus.data_snd_big !== {24{8'hA5}}) begin
         errors++;
         $display("FAIL single_data got %h want %h", bus.data_snd_big, {24{8'hA5}});
      end
      last_model = 0;
      exp_data = {24{8'hA5}};
      set_req(2'b00, '0, '0, '0, '0);
      tick();
      checks++;
      if (flags() !== 6'b0 || bus.amount_byte_snd_big !== 5'd5 || bus.data_snd_big !== exp_data) begin
         errors++;
         $display("FAIL single_hold got flags %b amt %0d want 000000 5", flags(), bus.amount_byte_snd_big);
      end
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0] d0, d1, ed;
      logic [AW-1:0] ea;
      int exp;
      d0 = {24{8'h11}};
      d1 = {24{8'h22}};
      set_req(2'b11, 5'd3, 5'd7, d0, d1);
      for (int i = 0; i < 4; i++) begin
`ifdef PKT_ARB_FIXED_PRIO_EN
         exp = 0;
`else
         exp = (last_model + 1) % NR;
`endif
         ea = (exp == 0) ? 5'd3 : 5'd7;
         ed = (exp == 0) ? d0 : d1;
         tick();
         checks++;
         if (bus.grant_id !== IW'(exp) || flags() !== {1'b1, 2'(1 << exp), 2'b00, 1'b1}) begin
            errors++;
            $display("FAIL b2b_grant%0d got id %0d flags %b want id %0d", i, bus.grant_id, flags(), exp);
         end
         checks++;
         if (bus.amount_byte_snd_big !== ea || bus.data_snd_big !== ed) begin
            errors++;
            $display("FAIL b2b_payload%0d got amt %0d want %0d", i, bus.amount_byte_snd_big, ea);
         end
         last_model = exp;
         exp_data = ed;
         tick();
         checks++;
         if (flags() !== 6'b0) begin
            errors++;
            $display("FAIL b2b_gap%0d got %b want 000000", i, flags());
         end
      end
      set_req(2'b00, '0, '0, '0, '0);
   endtask

   task automatic test_fifo_full();
      bus.available_snd = 1'b0;
      set_req(2'b10, 5'd0, 5'd9, '0, {24{8'h5A}});
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if (flags() !== 6'b0 || bus.data_snd_big !== exp_data) begin
            errors++;
            $display("FAIL full_hold%0d got flags %b data %h want 000000 %h", i, flags(),
                     bus.data_snd_big, exp_data);
         end
      end
      bus.available_snd = 1'b1;
      tick();
      checks++;
      if (flags() !== 6'b1_10_00_1 || bus.grant_id !== 1'b1 || bus.amount_byte_snd_big !== 5'd9) begin
         errors++;
         $display("FAIL full_release got flags %b id %0d amt %0d want 110001 1 9", flags(),
                  bus.grant_id, bus.amount_byte_snd_big);
      end
      last_model = 1;
      exp_data = {24{8'h5A}};
      set_req(2'b00, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_zero_clamp();
      set_req(2'b01, 5'd0, 5'd0, {24{8'hC3}}, '0);
      tick();
      checks++;
      if (flags() !== 6'b0_01_01_1 || bus.amount_byte_snd_big !== 5'd0) begin
         errors++;
         $display("FAIL zero_drop got flags %b amt %0d want 001011 0", flags(), bus.amount_byte_snd_big);
      end
      last_model = 0;
      set_req(2'b00, '0, '0, '0, '0);
      tick();
      set_req(2'b01, 5'd31, 5'd0, {24{8'h96}}, '0);
      tick();
      checks++;
      if (flags() !== 6'b1_01_00_1 || bus.amount_byte_snd_big !== 5'd24) begin
         errors++;
         $display("FAIL clamp got flags %b amt %0d want 101001 24", flags(), bus.amount_byte_snd_big);
      end
      set_req(2'b01, 5'd24, 5'd0, {24{8'h69}}, '0);
      tick();
      set_req(2'b00, '0, '0, '0, '0);
      tick();
      set_req(2'b01, 5'd24, 5'd0, {24{8'h69}}, '0);
      tick();
      checks++;
      if (flags() !== 6'b1_01_00_1 || bus.amount_byte_snd_big !== 5'd24) begin
         errors++;
         $display("FAIL exact_max got flags %b amt %0d want 101001 24", flags(), bus.amount_byte_snd_big);
      end
      last_model = 0;
      set_req(2'b00, '0, '0, '0, '0);
      tick();
   endtask

   task automatic test_reset_mid_issue();
      set_req(2'b10, 5'd0, 5'd4, '0, {24{8'hE7}});
      tick();
      checks++;
      if (flags() !== 6'b1_10_00_1) begin
         errors++;
         $display("FAIL mid_issue_enter got %b want 110001", flags());
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({flags(), bus.grant_id} !== 7'b0 || bus.data_snd_big !== '0 ||
          bus.amount_byte_snd_big !== '0) begin
         errors++;
         $display("FAIL mid_issue_reset got flags %b id %0d amt %0d want all 0", flags(),
                  bus.grant_id, bus.amount_byte_snd_big);
      end
      tick();
      rst = 1'b0;
      set_req(2'b11, 5'd2, 5'd6, {24{8'h0F}}, {24{8'hF0}});
      tick();
      checks++;
      if (bus.grant_id !== 1'b0 || flags() !== 6'b1_01_00_1 || bus.amount_byte_snd_big !== 5'd2) begin
         errors++;
         $display("FAIL post_reset_prio got id %0d flags %b want 0 101001", bus.grant_id, flags());
      end
      set_req(2'b00, '0, '0, '0, '0);
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_fifo_full();
      test_zero_clamp();
      test_reset_mid_issue();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
